burst_mem_arbiter: RTL
======================

Name: burst_mem_arbiter

Overview:
- Two-requester round-robin arbiter and burst sequencer in front of the burst memory (burst_transaction_top).
- Accepts whole-burst requests: base address, length, direction.
- Drives the memory's addr/wren/rden/burst_en/wr_data beat by beat and routes read data back to the owning requester.
- Signals completion of each burst with a done pulse.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 8, data width
BURST_LEN, 8, maximum beats per burst
RD_LAT, 1, memory read latency in cycles, rden/addr to valid mem_rd_data (legal 1..4)

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
req0, req1  in  1  burst request, level
we0, we1  in  1  1=write burst, 0=read burst; sampled at grant
addr0, addr1  in  ADDR_WIDTH  burst base address; sampled at grant
len0, len1  in  $clog2(BURST_LEN)+1  beat count; sampled at grant
wdata0, wdata1  in  DATA_WIDTH  write data; must be valid in the cycle wdata_rdyN is high
gnt0, gnt1  out  1  requester owns the memory
wdata_rdy0, wdata_rdy1  out  1  write beat issued this cycle; wdataN consumed
rvalid0, rvalid1  out  1  rdata valid for this requester
rdata  out  DATA_WIDTH  read data, shared bus
done0, done1  out  1  one-cycle burst-complete pulse
mem_addr  out  ADDR_WIDTH  to addr_top
mem_wren  out  1  to wren
mem_rden  out  1  to rden
mem_burst_en  out  1  to burst_en
mem_wr_data  out  DATA_WIDTH  to wr_data
mem_rd_data  in  DATA_WIDTH  from rd_data

Behaviour:
- Reset (asynchronous, rstn=0):
  - State IDLE.
  - All outputs 0.
  - Round-robin pointer last=1, so req0 wins the first tie.
  - Read pipeline cleared.
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - At a posedge where any reqN=1, grant the winner, latch weN/addrN/len, go to XFER.
  - Tie: grant the requester that is not "last"; then set last to the winner.
  - Single request: grant it regardless of pointer.
- Effective length:
  - len=0 becomes 1.
  - len>BURST_LEN is clamped to BURST_LEN.
- XFER:
  - gntN=1 from the first XFER cycle.
  - One beat per cycle, beat index k=0..L-1.
  - Beat 0 is on the memory bus in the cycle after the request is sampled (request-to-first-beat latency 1).
  - mem_addr = base+k, modulo 2^ADDR_WIDTH (wraps).
  - mem_burst_en = 0 for k=0, 1 for k>=1.
  - Write burst: mem_wren=1, wdata_rdyN=1, mem_wr_data=wdataN (combinational mux of the granted requester).
  - Read burst: mem_rden=1.
  - After beat L-1: write goes to IDLE; read goes to DRAIN.
- Read return:
  - RD_LAT-deep valid shift register.
  - rvalidN=1 exactly RD_LAT cycles after each read beat.
  - rdata = mem_rd_data when rvalid, else 0.
- DRAIN:
  - gntN stays 1 and memory controls stay 0.
  - When the last read beat's rvalid has been issued, go to IDLE.
- done:
  - doneN pulses 1 cycle, registered, in the first cycle after leaving XFER (write) or DRAIN (read).
  - gntN falls in that same cycle.
- Request handling:
  - Requests are ignored while busy, not queued.
  - A reqN still high in IDLE is treated as a new request, so the requester drops req after seeing gntN.
  - A burst is never preempted.
- Invariants:
  - Minimum one IDLE cycle between bursts.
  - At most one gnt high.
  - mem_wren and mem_rden never both high.
  - Memory controls are 0 outside XFER.
- Reset mid-burst: outputs drop to 0 immediately; no doneN; in-flight read data discarded; memory contents undefined for unfinished beats.

Test Plan:
- Write burst, req0 only, addr0=0x0010, len0=4, we0=1, wdata 0x11..0x14 -> 4 XFER cycles:
  - mem_addr 0x10..0x13, mem_burst_en 0,1,1,1, mem_wren=1, wdata_rdy0 4 pulses.
  - done0 pulses the next cycle.
- Read back, req1, addr1=0x0010, len1=4, RD_LAT=1 -> mem_rden 4 cycles; rvalid1 4 cycles offset by 1 with rdata 0x11,0x12,0x13,0x14; done1 after the last rvalid; rvalid0 never set.
- Fairness: req0 and req1 held high together for 4 bursts from reset, each len 2 -> grant order 0,1,0,1; one IDLE cycle between bursts; gnt0 and gnt1 never high together.
- Length rules: len0=0 -> exactly 1 beat; len0=12 -> exactly 8 beats; done0 once each.
- Wrap: write addr0=0xFFFE, len0=4 -> mem_addr 0xFFFE,0xFFFF,0x0000,0x0001.
- Reset: rstn=0 during beat 2 of an 8-beat write -> all outputs 0 in the same cycle, no done0; after release, state IDLE and a new req1 is granted first.

Source files
------------

// File: rtl/burst_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// burst_mem_arbiter_if
//
// Purpose:
//   Bundles every signal between the burst arbiter, its two requesters and
//   the burst memory, so the arbiter has a single bus port.
//
// Signal summary:
//   Requester N (N = 0,1):
//     reqN        level burst request
//     weN         1 = write burst, 0 = read burst (sampled at grant)
//     addrN       burst base address (sampled at grant)
//     lenN        beat count (sampled at grant, 0 -> 1, clamped to BURST_LEN)
//     wdataN      write data, must be valid while wdata_rdyN is high
//     gntN        requester owns the memory
//     wdata_rdyN  write beat issued this cycle
//     rvalidN     rdata belongs to this requester this cycle
//     doneN       one-cycle burst-complete pulse
//   Shared:
//     rdata       read data bus (0 when nothing is valid)
//   Memory side:
//     mem_addr, mem_wren, mem_rden, mem_burst_en, mem_wr_data  to memory
//     mem_rd_data                                              from memory
//
// Modports:
//   slave  - the arbiter
//   master - the environment (requesters plus memory)
// ---------------------------------------------------------------------------
interface burst_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 8
);
    localparam int LEN_WIDTH = $clog2(BURST_LEN) + 1;

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [LEN_WIDTH-1:0]  len0;
    logic [LEN_WIDTH-1:0]  len1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;

    logic                  gnt0;
    logic                  gnt1;
    logic                  wdata_rdy0;
    logic                  wdata_rdy1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  done0;
    logic                  done1;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wren;
    logic                  mem_rden;
    logic                  mem_burst_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
        input  mem_rd_data,
        output gnt0, gnt1, wdata_rdy0, wdata_rdy1, rvalid0, rvalid1, rdata,
        output done0, done1,
        output mem_addr, mem_wren, mem_rden, mem_burst_en, mem_wr_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
        output mem_rd_data,
        input  gnt0, gnt1, wdata_rdy0, wdata_rdy1, rvalid0, rvalid1, rdata,
        input  done0, done1,
        input  mem_addr, mem_wren, mem_rden, mem_burst_en, mem_wr_data
    );
endinterface

// File: rtl/burst_mem_arbiter.sv
// ---------------------------------------------------------------------------
// burst_mem_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter and burst sequencer in front of a burst
//   memory. A winning requester's whole burst (base, length, direction) is
//   latched at grant and then played onto the memory one beat per cycle.
//   Read data coming back from the memory is routed to the burst owner, and
//   every burst ends with a one-cycle done pulse to its owner.
//
// Ports:
//   clk   - clock, all logic on posedge
//   rstn  - asynchronous active-low reset
//   bus   - burst_mem_arbiter_if.slave, requester and memory signals
//
// Parameters:
//   ADDR_WIDTH - memory address width
//   DATA_WIDTH - data width
//   BURST_LEN  - maximum beats per burst
//   RD_LAT     - memory read latency in cycles (1..4)
// ---------------------------------------------------------------------------
module burst_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rstn,
    burst_mem_arbiter_if.slave  bus
);
    localparam int LEN_WIDTH = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic                  r_last;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [RD_LAT-1:0]     r_rdPipe;
    logic                  r_done0;
    logic                  r_done1;

    logic                  w_grant;
    logic                  w_winner;
    logic                  w_finish;
    logic                  w_beatRd;
    logic                  w_lastBeat;
    logic                  w_rvalid;
    logic [LEN_WIDTH-1:0]  w_reqLen;
    logic [LEN_WIDTH-1:0]  w_effLen;
    logic [RD_LAT-1:0]     w_pipeOlder;

    // Pick the winner among the current requests. With both requesting,
    // the one that did not win last time gets the memory; a lone request
    // wins regardless of the pointer. The winner's length is normalised
    // here: 0 means one beat, and anything beyond BURST_LEN is clamped.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_winner = ~r_last;
        end else begin
            w_winner = bus.req1;
        end

        w_reqLen = w_winner ? bus.len1 : bus.len0;

        if (w_reqLen == '0) begin
            w_effLen = LEN_WIDTH'(1);
        end else if (w_reqLen > LEN_WIDTH'(BURST_LEN)) begin
            w_effLen = LEN_WIDTH'(BURST_LEN);
        end else begin
            w_effLen = w_reqLen;
        end
    end

    // The beat counter reaches r_len-1 on the final beat of the burst.
    assign w_lastBeat = (r_beat == (r_len - LEN_WIDTH'(1)));

    // Every read-pipe stage except the oldest one; when that is empty and
    // the oldest stage is valid, the final read data is on rdata now.
    always_comb begin
        w_pipeOlder             = r_rdPipe;
        w_pipeOlder[RD_LAT-1]   = 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and all memory/handshake outputs. Everything is
    // decoded from registered state, so an asynchronous reset forces all of
    // these to zero immediately. Memory controls are only ever non-zero in
    // XFER; in DRAIN the owner keeps its grant while read data trickles back.
    always_comb begin
        w_nextState      = r_state;
        w_grant          = 1'b0;
        w_finish         = 1'b0;
        w_beatRd         = 1'b0;
        bus.gnt0         = 1'b0;
        bus.gnt1         = 1'b0;
        bus.wdata_rdy0   = 1'b0;
        bus.wdata_rdy1   = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wren     = 1'b0;
        bus.mem_rden     = 1'b0;
        bus.mem_burst_en = 1'b0;
        bus.mem_wr_data  = '0;

        case (r_state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grant     = 1'b1;
                    w_nextState = XFER;
                end
            end

            XFER: begin
                bus.gnt0         = ~r_owner;
                bus.gnt1         = r_owner;
                bus.mem_addr     = r_base + ADDR_WIDTH'(r_beat);
                bus.mem_burst_en = (r_beat != '0);
                if (r_we) begin
                    bus.mem_wren    = 1'b1;
                    bus.wdata_rdy0  = ~r_owner;
                    bus.wdata_rdy1  = r_owner;
                    bus.mem_wr_data = r_owner ? bus.wdata1 : bus.wdata0;
                end else begin
                    bus.mem_rden = 1'b1;
                    w_beatRd     = 1'b1;
                end
                if (w_lastBeat) begin
                    if (r_we) begin
                        w_nextState = IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_nextState = DRAIN;
                    end
                end
            end

            DRAIN: begin
                bus.gnt0 = ~r_owner;
                bus.gnt1 = r_owner;
                if (r_rdPipe[RD_LAT-1] && (w_pipeOlder == '0)) begin
                    w_nextState = IDLE;
                    w_finish    = 1'b1;
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Burst capture at grant time. The round-robin pointer remembers the
    // last winner; it resets to requester 1 so requester 0 wins the first
    // tie after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
        end else if (w_grant) begin
            r_last  <= w_winner;
            r_owner <= w_winner;
            r_we    <= w_winner ? bus.we1 : bus.we0;
            r_base  <= w_winner ? bus.addr1 : bus.addr0;
            r_len   <= w_effLen;
        end
    end

    // Beat index within the current burst; restarts at every grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat <= '0;
        end else if (w_grant) begin
            r_beat <= '0;
        end else if (r_state == XFER) begin
            r_beat <= r_beat + LEN_WIDTH'(1);
        end
    end

    // Read-return valid pipeline: a read beat issued in cycle t shows up at
    // the top stage in cycle t+RD_LAT, matching the memory's read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdPipe <= '0;
        end else begin
            r_rdPipe <= (r_rdPipe << 1) | RD_LAT'(w_beatRd);
        end
    end

    // Done pulses are registered so they land in the first cycle after the
    // burst has left XFER (write) or DRAIN (read), the same cycle gnt falls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_done0 <= w_finish & ~r_owner;
            r_done1 <= w_finish & r_owner;
        end
    end

    assign w_rvalid    = r_rdPipe[RD_LAT-1];
    assign bus.rvalid0 = w_rvalid & ~r_owner;
    assign bus.rvalid1 = w_rvalid & r_owner;
    assign bus.rdata   = w_rvalid ? bus.mem_rd_data : '0;
    assign bus.done0   = r_done0;
    assign bus.done1   = r_done1;

endmodule
